// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the register file
// Purpose : default geometry, register-number width derivation, zero-register
//           index and the byte-merge helper used by storage and bypass paths.
// Ports   : none (package).
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int ZERO_IDX  = 0;

    // Register-number width; a single-entry file would give 0 bits, so floor at 1.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One byte lane of a byte-enabled merge: new data where enabled, else old.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write/read bus bundle for the register file
// Purpose : groups the write port (We/Wn/D/Be) and the two read ports
//           (Rna/Qa, Rnb/Qb).
// Ports   : master drives We, Wn, D, Be, Rna, Rnb and receives Qa, Qb;
//           slave is the register file side.
interface register_file_if import regfile_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = calc_aw(DEPTH);

    logic               We;
    logic [AW-1:0]      Wn;
    logic [WIDTH-1:0]   D;
    logic [WIDTH/8-1:0] Be;
    logic [AW-1:0]      Rna;
    logic [AW-1:0]      Rnb;
    logic [WIDTH-1:0]   Qa;
    logic [WIDTH-1:0]   Qb;

    modport master (output We, Wn, D, Be, Rna, Rnb, input Qa, Qb);
    modport slave  (input We, Wn, D, Be, Rna, Rnb, output Qa, Qb);

endinterface

// File: rtl/dffec_word.sv
// rtl/dffec_word.sv - one WIDTH-bit word register with byte enables and clear
// Purpose : storage for a single register-file entry.
// Ports   : Clk  - clock, rising edge
//           Clr  - synchronous active-high clear, dominates the enables
//           i_en - per-byte write enable (bit i covers i_d[8i+7:8i])
//           i_d  - write data
//           o_q  - stored word
module dffec_word import regfile_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               Clk,
    input  logic               Clr,
    input  logic [WIDTH/8-1:0] i_en,
    input  logic [WIDTH-1:0]   i_d,
    output logic [WIDTH-1:0]   o_q
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        for (int b = 0; b < NB; b++) begin
            w_next[8*b +: 8] = merge_byte(r_q[8*b +: 8], i_d[8*b +: 8], i_en[b]);
        end
    end

    // Only load when some lane is enabled so idle words keep a quiet enable.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_q <= '0;
        end else if (|i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - DEPTH x WIDTH register file, 2 async reads, 1 write
// Purpose : general-purpose register file between decode and ALU/write-back,
//           with byte-enabled writes, optional write-to-read bypass and an
//           optional hard-wired zero register.
// Ports   : Clk - clock, rising edge
//           Clr - synchronous active-high clear of every register
//           bus - register_file_if.slave: We/Wn/D/Be write port,
//                 Rna->Qa and Rnb->Qb combinational read ports
module register_file import regfile_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            Clk,
    input  logic            Clr,
    register_file_if.slave  bus
);
    localparam int AW = calc_aw(DEPTH);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] w_q [DEPTH];

    // Storage: register 0 is a constant when ZERO_REG is set, so a write
    // addressed to it has nowhere to land and is dropped naturally.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if ((ZERO_REG != 0) && (i == ZERO_IDX)) begin : g_zero
            assign w_q[i] = '0;
        end else begin : g_word
            logic          w_sel;
            logic [NB-1:0] w_en;

            assign w_sel = bus.We && (bus.Wn == AW'(i));
            assign w_en  = w_sel ? bus.Be : '0;

            dffec_word #(.WIDTH(WIDTH)) u_word (
                .Clk  (Clk),
                .Clr  (Clr),
                .i_en (w_en),
                .i_d  (bus.D),
                .o_q  (w_q[i])
            );
        end
    end

    logic             w_wr_live;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [WIDTH-1:0] w_wr_cur;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_qa_raw;
    logic [WIDTH-1:0] w_qb_raw;

    // A write "lands" only if not cleared this edge and not aimed at the zero register.
    assign w_wr_live = bus.We && !Clr &&
                       !((ZERO_REG != 0) && (bus.Wn == AW'(ZERO_IDX)));

    assign w_wr_cur = w_q[bus.Wn];

    // Word the target register will hold after the edge; forwarded on a hit.
    always_comb begin
        w_merged = w_wr_cur;
        for (int b = 0; b < NB; b++) begin
            w_merged[8*b +: 8] = merge_byte(w_wr_cur[8*b +: 8], bus.D[8*b +: 8], bus.Be[b]);
        end
    end

    assign w_qa_raw = w_q[bus.Rna];
    assign w_qb_raw = w_q[bus.Rnb];

    assign w_hit_a = (BYPASS != 0) && w_wr_live && (bus.Rna == bus.Wn);
    assign w_hit_b = (BYPASS != 0) && w_wr_live && (bus.Rnb == bus.Wn);

    assign bus.Qa = w_hit_a ? w_merged : w_qa_raw;
    assign bus.Qb = w_hit_b ? w_merged : w_qb_raw;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
module tb_register_file;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic clr;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t sb[$];
    exp_t e;

    logic [31:0] mdl_m [32];   // main instance (ZERO_REG=1, BYPASS=1)
    logic [31:0] mdl_n [32];   // BYPASS=0 instance
    logic [15:0] mdl_s [8];    // 16-bit, 8-deep, ZERO_REG=0 instance

    register_file_if #(.WIDTH(32), .DEPTH(32)) bm ();
    register_file_if #(.WIDTH(32), .DEPTH(32)) bn ();
    register_file_if #(.WIDTH(16), .DEPTH(8))  bs ();

    register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_m (
        .Clk(clk), .Clr(clr), .bus(bm));
    register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .Clk(clk), .Clr(clr), .bus(bn));
    register_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) dut_s (
        .Clk(clk), .Clr(clr), .bus(bs));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bm.We = 1'b0; bn.We = 1'b0; bs.We = 1'b0;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++) begin mdl_m[i] = '0; mdl_n[i] = '0; end
        for (int i = 0; i < 8; i++) mdl_s[i] = '0;
    endtask

    // Drive a write on the main port and record its effect (r0 is hard zero).
    task automatic put_m(input int n, input logic [31:0] d, input logic [3:0] be);
        bm.We = 1'b1; bm.Wn = n[4:0]; bm.D = d; bm.Be = be;
        if (n != 0)
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl_m[n][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic put_n(input int n, input logic [31:0] d, input logic [3:0] be);
        bn.We = 1'b1; bn.Wn = n[4:0]; bn.D = d; bn.Be = be;
        if (n != 0)
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl_n[n][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic put_s(input int n, input logic [15:0] d, input logic [1:0] be);
        bs.We = 1'b1; bs.Wn = n[2:0]; bs.D = d; bs.Be = be;
        for (int b = 0; b < 2; b++)
            if (be[b]) mdl_s[n][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic test_reset();
        put_m(5, 32'hDEADBEEF, 4'hF); step(); idle_all();
        clr = 1'b1; step(); clr = 1'b0;
        clear_models();
        for (int i = 0; i < 32; i++) begin
            bm.Rna = i[4:0]; bm.Rnb = 5'(31 - i);
            sb.push_back('{name: $sformatf("reset_qa_r%0d", i), val: 32'h0});
            sb.push_back('{name: $sformatf("reset_qb_r%0d", 31 - i), val: 32'h0});
            @(negedge clk);
            e = sb.pop_front(); n_cmp++;
            if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
            e = sb.pop_front(); n_cmp++;
            if (bm.Qb !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qb, e.val); end
        end
    endtask

    task automatic test_full_write();
        step();
        for (int n = 1; n < 32; n++) begin
            put_m(n, 32'h01010101 * n, 4'hF); step();
        end
        put_m(0, 32'hFFFFFFFF, 4'hF); step(); idle_all();
        for (int i = 0; i < 32; i++) begin
            bm.Rna = i[4:0]; bm.Rnb = i[4:0];
            sb.push_back('{name: $sformatf("full_qa_r%0d", i), val: (i == 0) ? 32'h0 : 32'h01010101 * i});
            sb.push_back('{name: $sformatf("full_qb_r%0d", i), val: mdl_m[i]});
            @(negedge clk);
            e = sb.pop_front(); n_cmp++;
            if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
            e = sb.pop_front(); n_cmp++;
            if (bm.Qb !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qb, e.val); end
        end
    endtask

    task automatic test_byte_enables();
        step();
        put_m(7, 32'h11223344, 4'hF);  step();
        put_m(7, 32'hAABBCCDD, 4'b0101); step(); idle_all();
        bm.Rna = 5'd7; bm.Rnb = 5'd8;
        sb.push_back('{name: "be_r7", val: 32'h11BB33DD});
        sb.push_back('{name: "be_r8_untouched", val: 32'h08080808});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (bm.Qb !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qb, e.val); end
        step();
        put_m(7, 32'hFFFFFFFF, 4'b0000); step(); idle_all();
        sb.push_back('{name: "be_zero_noop", val: 32'h11BB33DD});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
    endtask

    task automatic test_bypass();
        step();
        put_m(9, 32'h0BADC0DE, 4'hF); put_n(9, 32'h0BADC0DE, 4'hF); step();
        // Same-cycle write and read of r9 on both instances.
        put_m(9, 32'h12345678, 4'hF); put_n(9, 32'h12345678, 4'hF);
        bm.Rna = 5'd9; bm.Rnb = 5'd9; bn.Rna = 5'd9; bn.Rnb = 5'd9;
        sb.push_back('{name: "byp_qa_new", val: 32'h12345678});
        sb.push_back('{name: "byp_qb_new", val: 32'h12345678});
        sb.push_back('{name: "nobyp_qa_old", val: 32'h0BADC0DE});
        sb.push_back('{name: "nobyp_qb_old", val: 32'h0BADC0DE});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (bm.Qb !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qb, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (bn.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bn.Qa, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (bn.Qb !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bn.Qb, e.val); end
        step(); idle_all();
        sb.push_back('{name: "nobyp_qa_next", val: 32'h12345678});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bn.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bn.Qa, e.val); end
        // Partial bypass: merged word, port B reads another register.
        step();
        put_m(9, 32'hAAAAAAAA, 4'b0011); bm.Rnb = 5'd10;
        sb.push_back('{name: "byp_partial_qa", val: 32'h1234AAAA});
        sb.push_back('{name: "byp_other_qb", val: 32'h0A0A0A0A});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (bm.Qb !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qb, e.val); end
        // Write to the zero register never forwards.
        step();
        put_m(0, 32'h55555555, 4'hF); bm.Rna = 5'd0;
        sb.push_back('{name: "byp_zero_reg", val: 32'h0});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
        step(); idle_all();
    endtask

    task automatic test_clr_vs_write();
        put_m(3, 32'h33333333, 4'hF); step(); idle_all();
        clr = 1'b1;
        bm.We = 1'b1; bm.Wn = 5'd3; bm.D = 32'hCAFEF00D; bm.Be = 4'hF;
        bm.Rna = 5'd3; bm.Rnb = 5'd3;
        sb.push_back('{name: "clr_cycle_no_bypass", val: 32'h33333333});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
        step(); clr = 1'b0; idle_all(); clear_models();
        bm.Rnb = 5'd7;
        sb.push_back('{name: "clr_r3_lost", val: 32'h0});
        sb.push_back('{name: "clr_r7_cleared", val: 32'h0});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (bm.Qb !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qb, e.val); end
        step();
        put_m(3, 32'h5A5A5A5A, 4'hF); step(); idle_all();
        sb.push_back('{name: "post_clr_write", val: 32'h5A5A5A5A});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
    endtask

    task automatic test_param_sweep();
        step();
        put_s(0, 16'hBEEF, 2'b11); step();
        for (int i = 1; i < 7; i++) begin put_s(i, 16'(16'h1100 * i + i), 2'b11); step(); end
        put_s(7, 16'hFFFF, 2'b11); step(); idle_all();
        for (int i = 0; i < 8; i++) begin
            bs.Rna = i[2:0]; bs.Rnb = 3'(7 - i);
            sb.push_back('{name: $sformatf("sweep_qa_r%0d", i), val: {16'h0, mdl_s[i]}});
            sb.push_back('{name: $sformatf("sweep_qb_r%0d", 7 - i), val: {16'h0, mdl_s[7 - i]}});
            @(negedge clk);
            e = sb.pop_front(); n_cmp++;
            if ({16'h0, bs.Qa} !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bs.Qa, e.val); end
            e = sb.pop_front(); n_cmp++;
            if ({16'h0, bs.Qb} !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bs.Qb, e.val); end
        end
        bs.Rna = 3'd0;
        sb.push_back('{name: "sweep_r0_writable", val: 32'h0000BEEF});
        @(negedge clk);
        e = sb.pop_front(); n_cmp++;
        if ({16'h0, bs.Qa} !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bs.Qa, e.val); end
    endtask

    task automatic test_back_to_back();
        step();
        for (int n = 10; n < 18; n++) begin
            put_m(n, $urandom, 4'($urandom_range(0, 15)));
            step();
        end
        idle_all();
        for (int n = 10; n < 18; n++) begin
            bm.Rna = n[4:0]; bm.Rnb = 5'(n + 8);
            sb.push_back('{name: $sformatf("b2b_qa_r%0d", n), val: mdl_m[n]});
            sb.push_back('{name: $sformatf("b2b_qb_r%0d", n + 8), val: mdl_m[n + 8]});
            @(negedge clk);
            e = sb.pop_front(); n_cmp++;
            if (bm.Qa !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qa, e.val); end
            e = sb.pop_front(); n_cmp++;
            if (bm.Qb !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, bm.Qb, e.val); end
        end
    endtask

    initial begin
        clr = 1'b1;
        bm.We = 1'b0; bm.Wn = '0; bm.D = '0; bm.Be = '0; bm.Rna = '0; bm.Rnb = '0;
        bn.We = 1'b0; bn.Wn = '0; bn.D = '0; bn.Be = '0; bn.Rna = '0; bn.Rnb = '0;
        bs.We = 1'b0; bs.Wn = '0; bs.D = '0; bs.Be = '0; bs.Rna = '0; bs.Rnb = '0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        clear_models();

        test_reset();
        test_full_write();
        test_byte_enables();
        test_bypass();
        test_clr_vs_write();
        test_param_sweep();
        test_back_to_back();

        n_cmp++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
